// File: rtl/mult_lastn.sv
// Streaming fold over the last N accepted samples: product (mode 0) or sum (mode 1).
// An accepted sample starts an (N-1)-cycle iterative fold; samples equal to ign_r are discarded.
module mult_lastn #(
    parameter int W   = 4,
    parameter int N   = 3,
    parameter int IGN = 0
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic [W-1:0]     in,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             ld,
    input  logic             mode,
    output logic [N*W-1:0]   out,
    output logic             out_valid,
    output logic             full
);

    localparam int AW = N * W;
    localparam int IW = $clog2(N);
    localparam int CW = $clog2(N + 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        CALC = 1'b1
    } state_t;

    state_t          state_r;
    state_t          state_nxt_s;
    logic [W-1:0]    win_r [N];
    logic [W-1:0]    ign_r;
    logic [CW-1:0]   cnt_r;
    logic [AW-1:0]   acc_r;
    logic [IW-1:0]   idx_r;
    logic            op_r;
    logic [AW-1:0]   out_r;
    logic            out_valid_r;
    logic            full_r;
    logic            accept_s;
    logic            take_s;
    logic            last_s;
    logic [AW-1:0]   fold_s;

    // One fold step; the window operand is zero-extended to the accumulator width.
    function automatic logic [AW-1:0] fold_step(input logic [AW-1:0] a,
                                                input logic [W-1:0]  b,
                                                input logic          op);
        logic [AW-1:0] bx;
        bx = {{(AW - W){1'b0}}, b};
        if (op) begin
            return a + bx;
        end else begin
            return a * bx;
        end
    endfunction

    assign accept_s  = in_valid && in_ready;
    assign take_s    = accept_s && (in != ign_r);
    assign last_s    = (state_r == CALC) && (idx_r == IW'(N - 1));
    assign fold_s    = fold_step(acc_r, win_r[idx_r], op_r);
    assign out       = out_r;
    assign out_valid = out_valid_r;
    assign full      = full_r;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (take_s) begin
                    state_nxt_s = CALC;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            CALC: begin
                if (last_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = CALC;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // FSM outputs: a pending load blocks acceptance for that cycle.
    always_comb begin
        in_ready = 1'b0;
        if ((state_r == IDLE) && !ld) begin
            in_ready = 1'b1;
        end else begin
            in_ready = 1'b0;
        end
    end

    // Datapath: ignore register, sample window, fold accumulator and result.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            for (int i = 0; i < N; i++) begin
                win_r[i] <= '0;
            end
            ign_r       <= W'(IGN);
            cnt_r       <= '0;
            acc_r       <= '0;
            idx_r       <= '0;
            op_r        <= 1'b0;
            out_r       <= '0;
            out_valid_r <= 1'b0;
            full_r      <= 1'b0;
        end else begin
            if (ld) begin
                ign_r <= in;
            end
            if (take_s) begin
                win_r[0] <= in;
                for (int i = 1; i < N; i++) begin
                    win_r[i] <= win_r[i-1];
                end
                if (cnt_r != CW'(N)) begin
                    cnt_r <= cnt_r + CW'(1);
                end
                full_r <= (cnt_r >= CW'(N - 1));
                acc_r  <= {{(AW - W){1'b0}}, in};
                idx_r  <= IW'(1);
                op_r   <= mode;
            end else if (state_r == CALC) begin
                acc_r <= fold_s;
                idx_r <= idx_r + IW'(1);
            end
            out_valid_r <= last_s;
            if (last_s) begin
                out_r <= fold_s;
            end
        end
    end

endmodule

// File: tb/tb_mult_lastn.sv
// Directed, table-driven bench for mult_lastn: a default instance (W=4,N=3) and a W=6,N=2 instance.
module tb_mult_lastn;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_b;
    logic [3:0]  in_a;
    logic        vld_a, ld_a, mode_a, rdy_a, ov_a, full_a;
    logic [11:0] out_a;
    logic [5:0]  in_b;
    logic        vld_b, ld_b, mode_b, rdy_b, ov_b, full_b;
    logic [11:0] out_b;

    mult_lastn #(.W(4), .N(3), .IGN(0)) dut_a (
        .clk(clk), .rst_b(rst_b), .in(in_a), .in_valid(vld_a), .in_ready(rdy_a),
        .ld(ld_a), .mode(mode_a), .out(out_a), .out_valid(ov_a), .full(full_a)
    );

    mult_lastn #(.W(6), .N(2), .IGN(0)) dut_b (
        .clk(clk), .rst_b(rst_b), .in(in_b), .in_valid(vld_b), .in_ready(rdy_b),
        .ld(ld_b), .mode(mode_b), .out(out_b), .out_valid(ov_b), .full(full_b)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        bit sel;       // 0 = instance A, 1 = instance B
        bit is_ld;
        int v;
        bit m;
        bit take;      // sample expected to start a computation
        int exp_out;
        bit exp_full;
    } vec_t;

    vec_t vt[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input bit sel, input logic [5:0] v, input logic m,
                         input logic valid, input logic l);
        if (sel) begin
            in_b = v; mode_b = m; vld_b = valid; ld_b = l;
        end else begin
            in_a = v[3:0]; mode_a = m; vld_a = valid; ld_a = l;
        end
    endtask

    function automatic logic get_rdy(input bit sel);
        return sel ? rdy_b : rdy_a;
    endfunction
    function automatic logic get_ov(input bit sel);
        return sel ? ov_b : ov_a;
    endfunction
    function automatic logic [11:0] get_out(input bit sel);
        return sel ? out_b : out_a;
    endfunction
    function automatic logic get_full(input bit sel);
        return sel ? full_b : full_a;
    endfunction

    task automatic run_vec(input int k, input vec_t t);
        int n;
        int w;
        int low;
        int pulses;
        int pos;
        logic [5:0] v;
        n = t.sel ? 2 : 3;
        v = t.v[5:0];
        low = 0; pulses = 0; pos = -1; w = 0;
        if (t.is_ld) begin
            @(negedge clk);
            drive(t.sel, v, t.m, 1'b1, 1'b1);
            #1 check($sformatf("v%0d ready_during_ld", k), get_rdy(t.sel), 1'b0);
            @(negedge clk);
            drive(t.sel, 6'd0, t.m, 1'b0, 1'b0);
            #1 check($sformatf("v%0d ready_after_ld", k), get_rdy(t.sel), 1'b1);
            check($sformatf("v%0d no_pulse_ld", k), get_ov(t.sel), 1'b0);
        end else begin
            @(negedge clk);
            drive(t.sel, v, t.m, 1'b1, 1'b0);
            while (!get_rdy(t.sel) && w < 10) begin
                @(negedge clk);
                w++;
            end
            if (w >= 10) check($sformatf("v%0d wait_ready_timeout", k), 32'd0, 32'd1);
            @(negedge clk);
            drive(t.sel, 6'd0, !t.m, 1'b0, 1'b0);
            for (int i = 0; i < n + 2; i++) begin
                if (i > 0) @(negedge clk);
                if (!get_rdy(t.sel)) low++;
                if (get_ov(t.sel)) begin
                    pulses++;
                    pos = i;
                end
            end
            check($sformatf("v%0d pulses", k), pulses, t.take ? 1 : 0);
            check($sformatf("v%0d ready_low", k), low, t.take ? n - 1 : 0);
            if (t.take) check($sformatf("v%0d pulse_pos", k), pos, n - 1);
            check($sformatf("v%0d out", k), get_out(t.sel), t.exp_out);
            check($sformatf("v%0d full", k), get_full(t.sel), t.exp_full);
        end
    endtask

    initial begin
        int pulses;
        rst_b = 1'b0;
        drive(1'b0, 6'd0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 6'd0, 1'b0, 1'b0, 1'b0);

        //             sel ld  v  m  take out   full
        vt.push_back('{0, 0,  2, 0, 1,    0,    0});
        vt.push_back('{0, 0,  3, 0, 1,    0,    0});
        vt.push_back('{0, 0,  4, 0, 1,   24,    1});
        vt.push_back('{0, 0,  0, 0, 0,   24,    1});
        vt.push_back('{0, 0,  5, 0, 1,   60,    1});
        vt.push_back('{0, 1,  5, 0, 0,    0,    0});
        vt.push_back('{0, 0,  5, 0, 0,   60,    1});
        vt.push_back('{0, 0,  7, 0, 1,  140,    1});
        vt.push_back('{0, 0, 15, 1, 1,   27,    1});
        vt.push_back('{0, 0, 15, 1, 1,   37,    1});
        vt.push_back('{0, 0, 15, 1, 1,   45,    1});
        vt.push_back('{0, 0, 15, 0, 1, 3375,    1});

        repeat (2) @(negedge clk);
        check("rst out_a", out_a, 12'd0);
        check("rst ov_a", ov_a, 1'b0);
        check("rst full_a", full_a, 1'b0);
        check("rst out_b", out_b, 12'd0);
        check("rst full_b", full_b, 1'b0);
        rst_b = 1'b1;
        #1 check("rst ready_a", rdy_a, 1'b1);

        foreach (vt[i]) run_vec(i, vt[i]);

        // Reset one cycle after an accept aborts the computation.
        @(negedge clk);
        drive(1'b0, 6'd3, 1'b0, 1'b1, 1'b0);
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, 6'd0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1 rst_b = 1'b0;
        #1;
        check("midrst out", out_a, 12'd0);
        check("midrst ov", ov_a, 1'b0);
        check("midrst full", full_a, 1'b0);
        @(negedge clk);
        rst_b = 1'b1;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (ov_a) pulses++;
        end
        check("midrst no_pulse", pulses, 0);
        run_vec(100, '{0, 0, 0, 0, 0, 0, 0});
        run_vec(101, '{0, 0, 6, 0, 1, 0, 0});

        vt.delete();
        vt.push_back('{1, 0, 10, 0, 1,    0, 0});
        vt.push_back('{1, 0,  5, 0, 1,   50, 1});
        vt.push_back('{1, 0, 63, 0, 1,  315, 1});
        vt.push_back('{1, 0, 63, 0, 1, 3969, 1});
        foreach (vt[i]) run_vec(200 + i, vt[i]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mult_lastn.md
Name: mult_lastn

Overview:
- Streaming arithmetic block that combines the last N accepted (non-ignored) input samples.
- Result is the product (mode 0) or the sum (mode 1) of the window.
- Generalises the two-sample multiplier: parametrised window depth, valid/ready input handshake, multi-cycle iterative fold, selectable op, loadable ignore value.
- Sits between a sample source and a result consumer in the arithmetic datapath.

Parameters:
- W, 4, sample width in bits.
- N, 3, window depth (number of samples combined); legal range 2..8.
- IGN, 0, ignore value loaded at reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_b  in  1  reset, asynchronous, active-low.
- in  in  W  sample data; also the new ignore value when ld=1.
- in_valid  in  1  sample present on in.
- in_ready  out  1  block can accept a sample this cycle.
- ld  in  1  synchronous ignore-value load, active-high.
- mode  in  1  0 = product, 1 = sum; sampled on accept.
- out  out  N*W  last completed result.
- out_valid  out  1  one-cycle pulse when out is updated.
- full  out  1  N non-ignored samples accepted since reset.

Behaviour:
- Reset (rst_b=0, async, any state, including mid-computation):
  - out=0, out_valid=0, full=0.
  - Window registers win[0..N-1]=0; fill count=0; ign_reg=IGN; FSM=IDLE; any computation in progress is aborted.
- in_ready = (state==IDLE) && !ld. Combinational from registered state and ld.
- ld=1 at an edge: ign_reg<=in.
  - No sample is accepted that edge, regardless of in_valid.
  - Allowed in any state; a CALC in progress continues unaffected.
- Accept = in_valid && in_ready at an edge.
  - in==ign_reg: sample discarded. No window change, no computation, no out_valid; stays IDLE.
  - Otherwise (edge k):
    - Window shifts: win[0]<=in (newest), win[i]<=win[i-1].
    - Fill count increments, saturating at N; full<=1 when count reaches N.
    - acc<=in; idx<=1; op<=mode; state<=CALC.
- FSM IDLE -> CALC -> IDLE:
  - CALC, edges k+1..k+N-1: acc <= acc*win[idx] (op=0) or acc+win[idx] (op=1); idx++.
  - At edge k+N-1 the final fold writes out, out_valid<=1 for exactly one cycle, state<=IDLE.
  - in_ready is low for the N-1 cycles of CALC; next accept is possible at edge k+N.
- Before the window is full, empty slots hold 0: product results are 0 and sums are partial. out is still updated and out_valid still pulses; only full distinguishes the two cases.
- Widths:
  - acc and out are N*W bits; operands are zero-extended.
  - Max product (2^W-1)^N and max sum N*(2^W-1) fit without overflow.
  - Unsigned arithmetic only.
- mode changes during CALC have no effect on the current computation (op is latched).
- in_valid high while in_ready is low: the sample is not taken. The source must hold it (standard valid/ready).
- out holds its value between completions.

Test Plan:
- Defaults (W=4,N=3,IGN=0), mode=0, feed 2,3,4 back-to-back with valid held:
  - After 2: out=0, full=0.
  - After 3: out=0.
  - After 4: out=24, full=1; out_valid pulses 2 cycles after the accept edge.
  - in_ready is low 2 cycles after each accept.
- Ignore: after window {4,3,2}, feed 0 -> no out_valid, out stays 24. Then feed 5 -> out=60.
- Load: ld=1 with in=5; then feed 5 -> ignored. Then feed 7 -> window {7,5,4}, out=140.
- Sum mode and max width: mode=1, feed 15,15,15 -> out=45. mode=0, feed 15 -> out=3375 (12-bit max, no overflow).
- Reset mid-CALC: assert rst_b=0 one cycle after an accept:
  - out=0, out_valid=0, full=0 immediately (async); no pulse afterwards.
  - ign_reg is back to IGN: feed 0 -> ignored.
- N=2, W=6 instance: feed 10,5,63,63 -> out sequence 0,50,315,3969; in_ready low 1 cycle per accept.
